mem_access_unit: RTL and testbench

Load/store sequencer between the CPU execute stage and `DataMemory`, upstream of the memory. Accepts one memory request at a time over a valid/ready handshake and drives `DataMemory`'s Address/WriteData/MemWrite/MemRead strobes. Implements word and byte loads, with sign or zero extension, and word and byte stores. A byte store is a read-modify-write of the containing 16-bit word. Returns load data or an error flag over a second valid/ready handshake.

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and DataMemory.
// One request at a time; byte stores are read-modify-write of the containing word.
module mem_access_unit #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] MemAddress,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] MemReadData
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
    typedef enum logic [2:0] {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB} op_t;

    state_t      state, next_state;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] merge_q;
    logic [15:0] rsp_data_q;
    logic        rsp_err_q;

    logic        req_bad;
    logic        is_load;
    logic [7:0]  sel_byte;
    logic [15:0] load_value;
    logic [15:0] merged_word;
    logic [15:0] word_addr;

    // Decode of the live request, only meaningful at the IDLE handshake
    always_comb begin
        req_bad = 1'b0;
        if (req_op > OP_SB)
            req_bad = 1'b1;
        else if (MISALIGN_TRAP && req_addr[0] && (req_op == OP_LW || req_op == OP_SW))
            req_bad = 1'b1;
    end

    assign is_load   = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU);
    assign word_addr = {addr_q[15:1], 1'b0};
    assign sel_byte  = addr_q[0] ? MemReadData[15:8] : MemReadData[7:0];

    always_comb begin
        load_value = MemReadData;
        if (op_q == OP_LB)
            load_value = {{8{sel_byte[7]}}, sel_byte};
        else if (op_q == OP_LBU)
            load_value = {8'h00, sel_byte};
    end

    assign merged_word = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]}
                                   : {merge_q[15:8], wdata_q[7:0]};

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    next_state = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                MemAddress = word_addr;
                if (is_load) begin
                    MemRead    = 1'b1;
                    next_state = RESP;
                end else if (op_q == OP_SW) begin
                    MemWrite     = 1'b1;
                    MemWriteData = wdata_q;
                    next_state   = RESP;
                end else if (op_q == OP_SB) begin
                    MemRead    = 1'b1;
                    next_state = MERGE;
                end else begin
                    next_state = RESP;
                end
            end
            MERGE: begin
                MemAddress   = word_addr;
                MemWrite     = 1'b1;
                MemWriteData = merged_word;
                next_state   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rsp_data_q <= '0;
                        rsp_err_q  <= req_bad;
                    end
                end
                ACCESS: begin
                    if (is_load)
                        rsp_data_q <= load_value;
                    else if (op_q == OP_SB)
                        merge_q <= MemReadData;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural DataMemory and a response scoreboard.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] MemAddress;
    logic [15:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] MemReadData;

    mem_access_unit #(.MISALIGN_TRAP(1'b1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clock) if (MemWrite) mem[MemAddress[8:1]] <= MemWriteData;
    assign MemReadData = mem[MemAddress[8:1]];

    int unsigned rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [15:0] last_wa = '0, last_wd = '0;
    always @(posedge clock) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) begin
            wr_cnt++;
            last_wa = MemAddress;
            last_wd = MemWriteData;
        end
        if (MemRead && MemWrite) both_cnt++;
    end

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    int tests = 0;
    int failures = 0;

    localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, SW = 3'b011, SB = 3'b100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check(input string tag);
        rsp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, {16'h0, rsp_data}, {16'h0, e.data});
            check({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
        end
    endtask

    // Full transaction with rsp_ready held high; checks latency, response and strobe counts.
    task automatic do_req(input string tag, input logic [2:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic err, input logic [15:0] data,
                          input int lat_exp, input int rd_exp, input int wr_exp);
        int unsigned rd0, wr0;
        int lat;
        rsp_t e;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        e.err = err;
        e.data = data;
        sb_q.push_back(e);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; req_op = 3'b111; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, lat_exp);
        if (rsp_valid) pop_check(tag);
        tick();
        check({tag, "_rsp_done"}, {31'h0, rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'h0, req_ready}, 32'd1);
        check({tag, "_reads"}, rd_cnt - rd0, rd_exp);
        check({tag, "_writes"}, wr_cnt - wr0, wr_exp);
    endtask

    initial begin
        int unsigned rd0, wr0;
        logic [15:0] held;
        rsp_t e;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'h0, rsp_data}, 32'd0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        check("rst_strobes", {30'h0, MemWrite, MemRead}, 32'd0);
        check("rst_addr", {16'h0, MemAddress}, 32'd0);
        check("rst_wdata", {16'h0, MemWriteData}, 32'd0);
        reset_n = 1'b1;
        tick();

        do_req("sw_0c", SW, 16'h000C, 16'h0012, 1'b0, 16'h0000, 2, 0, 1);
        check("sw_0c_waddr", {16'h0, last_wa}, 32'h000C);
        check("sw_0c_wdata", {16'h0, last_wd}, 32'h0012);
        do_req("lw_0c", LW, 16'h000C, 16'h0000, 1'b0, 16'h0012, 2, 1, 0);

        do_req("sw_20", SW, 16'h0020, 16'h80F0, 1'b0, 16'h0000, 2, 0, 1);
        do_req("lb_21", LB, 16'h0021, 16'h0000, 1'b0, 16'hFF80, 2, 1, 0);
        do_req("lbu_21", LBU, 16'h0021, 16'h0000, 1'b0, 16'h0080, 2, 1, 0);
        do_req("lb_20", LB, 16'h0020, 16'h0000, 1'b0, 16'hFFF0, 2, 1, 0);
        do_req("lbu_20", LBU, 16'h0020, 16'h0000, 1'b0, 16'h00F0, 2, 1, 0);

        do_req("sw_40", SW, 16'h0040, 16'h1234, 1'b0, 16'h0000, 2, 0, 1);
        do_req("sb_41", SB, 16'h0041, 16'h00AB, 1'b0, 16'h0000, 3, 1, 1);
        check("sb_41_waddr", {16'h0, last_wa}, 32'h0040);
        check("sb_41_wdata", {16'h0, last_wd}, 32'hAB34);
        do_req("lw_40", LW, 16'h0040, 16'h0000, 1'b0, 16'hAB34, 2, 1, 0);
        do_req("sb_40", SB, 16'h0040, 16'h55CD, 1'b0, 16'h0000, 3, 1, 1);
        do_req("lw_40b", LW, 16'h0040, 16'h0000, 1'b0, 16'hABCD, 2, 1, 0);

        do_req("lw_mis", LW, 16'h0003, 16'h0000, 1'b1, 16'h0000, 1, 0, 0);
        do_req("sw_mis", SW, 16'h0005, 16'h7777, 1'b1, 16'h0000, 1, 0, 0);
        do_req("op_110", 3'b110, 16'h0040, 16'h0000, 1'b1, 16'h0000, 1, 0, 0);
        do_req("lw_after_err", LW, 16'h0040, 16'h0000, 1'b0, 16'hABCD, 2, 1, 0);

        // Backpressure: hold rsp_ready low for 5 cycles with a stray request pulse.
        rd0 = rd_cnt;
        e.err = 1'b0; e.data = 16'h0012;
        sb_q.push_back(e);
        rsp_ready = 1'b0;
        req_op = LW; req_addr = 16'h000C; req_wdata = '0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("bp_latency", {31'h0, rsp_valid}, 32'd1);
        held = rsp_data;
        pop_check("bp");
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 2);
            req_op = SW; req_addr = 16'h0020; req_wdata = 16'hDEAD;
            tick();
            check("bp_valid", {31'h0, rsp_valid}, 32'd1);
            check("bp_data", {16'h0, rsp_data}, {16'h0, held});
            check("bp_req_ready", {31'h0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_released", {31'h0, rsp_valid}, 32'd0);
        tick();
        tick();
        check("bp_reads", rd_cnt - rd0, 32'd1);
        check("bp_no_stray", {31'h0, req_ready}, 32'd1);
        do_req("bp_mem_intact", LW, 16'h0020, 16'h0000, 1'b0, 16'h80F0, 2, 1, 0);

        // Reset during SB ACCESS drops the request without touching memory.
        do_req("sw_60", SW, 16'h0060, 16'h4321, 1'b0, 16'h0000, 2, 0, 1);
        wr0 = wr_cnt;
        req_op = SB; req_addr = 16'h0060; req_wdata = 16'h0099; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rstsb_in_access", {31'h0, MemRead}, 32'd1);
        reset_n = 1'b0;
        tick();
        check("rstsb_req_ready", {31'h0, req_ready}, 32'd1);
        check("rstsb_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rstsb_mw", {31'h0, MemWrite}, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        check("rstsb_rsp_quiet", {31'h0, rsp_valid}, 32'd0);
        check("rstsb_writes", wr_cnt - wr0, 32'd0);
        do_req("rstsb_lw", LW, 16'h0060, 16'h0000, 1'b0, 16'h4321, 2, 1, 0);

        check("both_strobes", both_cnt, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
